// File: rtl/switch_pkg.sv
// Shared constants and types for the N:1 egress merge slice.
package switch_pkg;

    localparam int SWITCH_WIDTH = 64;
    localparam int SWITCH_PORTS = 16;
    localparam int SWITCH_IDXW  = $clog2(SWITCH_PORTS);

    typedef logic [SWITCH_IDXW-1:0]  port_idx_t;
    typedef logic [SWITCH_WIDTH-1:0] word_t;

endpackage

// File: rtl/switch_merge_if.sv
// Per-port ingress handshake plus the single egress stream of switch_merge.
interface switch_merge_if
    import switch_pkg::*;
#(
    parameter int WIDTH = SWITCH_WIDTH,
    parameter int PORTS = SWITCH_PORTS,
    parameter int IDXW  = $clog2(PORTS)
) ();

    logic [PORTS-1:0] in_valid;
    logic [WIDTH-1:0] in_data [PORTS-1:0];
    logic [PORTS-1:0] in_last;
    logic [PORTS-1:0] in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0]  out_port;
    logic             out_last;
    logic             out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_port, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_port, out_last
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from rr_ptr, or grants only lock_idx when locked.
module rr_arbiter #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic          advance,
    input  logic          lock,
    input  logic [IW-1:0] lock_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] cand;
    logic          hit;

    // N is a power of two, so the IW-bit sum wraps PORTS-1 -> 0 for free.
    always_comb begin
        hit     = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        gnt     = '0;
        if (lock) begin
            hit     = req[lock_idx];
            gnt_idx = lock_idx;
        end else begin
            for (int i = 0; i < N; i++) begin
                cand = rr_ptr + IW'(i);
                if (!hit && req[cand]) begin
                    hit     = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (enable && hit) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/switch_merge.sv
// N:1 round-robin merge with one registered egress stage.
// Optional packet lock with SWITCH_MERGE_LOCK_EN.
module switch_merge
    import switch_pkg::*;
#(
    parameter int WIDTH = SWITCH_WIDTH,
    parameter int PORTS = SWITCH_PORTS,
    parameter int IDXW  = $clog2(PORTS)
) (
    input logic           clk,
    input logic           rst,
    switch_merge_if.slave bus
);

    logic             load_en;
    logic             xfer;
    logic             advance;
    logic             lock;
    logic [IDXW-1:0]  lock_port;
    logic [IDXW-1:0]  g;
    logic [PORTS-1:0] gnt;

    assign load_en = !bus.out_valid || bus.out_ready;

    rr_arbiter #(
        .N  (PORTS),
        .IW (IDXW)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.in_valid),
        .enable   (load_en && !rst),
        .advance  (advance),
        .lock     (lock),
        .lock_idx (lock_port),
        .gnt      (gnt),
        .gnt_idx  (g)
    );

    assign bus.in_ready = gnt;
    assign xfer         = |gnt;

`ifdef SWITCH_MERGE_LOCK_EN
    // Pointer only moves when a packet closes, so a lock never shifts fairness.
    assign advance = xfer && bus.in_last[g];

    always_ff @(posedge clk) begin
        if (rst) begin
            lock      <= 1'b0;
            lock_port <= '0;
        end else if (xfer) begin
            lock      <= !bus.in_last[g];
            lock_port <= g;
        end
    end
`else
    assign advance   = xfer;
    assign lock      = 1'b0;
    assign lock_port = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_port  <= '0;
            bus.out_last  <= 1'b0;
        end else if (load_en) begin
            bus.out_valid <= xfer;
            if (xfer) begin
                bus.out_data <= bus.in_data[g];
                bus.out_port <= g;
                bus.out_last <= bus.in_last[g];
            end
        end
    end

endmodule

// File: tb/tb_switch_merge.sv
// Randomized scoreboard bench for switch_merge against a queue-based reference.
// Honours SWITCH_MERGE_LOCK_EN in the reference model as well.
module tb_switch_merge;
    import switch_pkg::*;

    localparam int P = SWITCH_PORTS;
    localparam int W = SWITCH_WIDTH;

    typedef struct {
        int         port;
        logic [W-1:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b0;

    always #5 clk = ~clk;

    switch_merge_if #(.WIDTH(W), .PORTS(P)) bus ();

    switch_merge #(.WIDTH(W), .PORTS(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    beat_t q[$];
    bit    m_valid = 0;
    int    m_rr    = 0;
    bit    m_lock  = 0;
    int    m_lport = 0;

    bit           stall_prev = 0;
    logic [W-1:0] stall_d;
    logic [3:0]   stall_p;

    always @(posedge clk) rst_q <= rst;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what should be granted this cycle, and what the egress owes.
    always @(negedge clk) begin
        int          g;
        bit          le;
        logic [P-1:0] er;
        if (rst) begin
            check("in_ready_rst", 64'(bus.in_ready), 64'd0);
            q.delete();
            m_valid = 0;
            m_rr    = 0;
            m_lock  = 0;
        end else begin
            check("out_valid", 64'(bus.out_valid), 64'(m_valid));
            le = !m_valid || bus.out_ready;
            g  = -1;
            if (le) begin
                if (m_lock) begin
                    if (bus.in_valid[m_lport]) g = m_lport;
                end else begin
                    for (int i = 0; i < P; i++)
                        if (g < 0 && bus.in_valid[(m_rr + i) % P])
                            g = (m_rr + i) % P;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            check("in_ready", 64'(bus.in_ready), 64'(er));
            if (g >= 0) begin
                q.push_back('{g, bus.in_data[g], bus.in_last[g]});
`ifdef SWITCH_MERGE_LOCK_EN
                if (bus.in_last[g]) begin
                    m_lock = 0;
                    m_rr   = (g + 1) % P;
                end else begin
                    m_lock  = 1;
                    m_lport = g;
                end
`else
                m_rr = (g + 1) % P;
`endif
            end
            if (le) m_valid = (g >= 0);
        end
    end

    // Monitor: egress handshakes, reset values and stall stability.
    always @(negedge clk) begin
        beat_t b;
        if (rst_q) begin
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_data",  bus.out_data,       64'd0);
            check("rst_out_port",  64'(bus.out_port),  64'd0);
            check("rst_out_last",  64'(bus.out_last),  64'd0);
        end
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev && !rst_q) begin
                check("stall_data",  bus.out_data,       stall_d);
                check("stall_port",  64'(bus.out_port),  64'(stall_p));
                check("stall_valid", 64'(bus.out_valid), 64'd1);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_d    = bus.out_data;
            stall_p    = bus.out_port;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL egress: unexpected beat port %0d", bus.out_port);
                end else begin
                    b = q.pop_front();
                    check("out_port", 64'(bus.out_port), 64'(b.port));
                    check("out_data", bus.out_data,      b.data);
                    check("out_last", 64'(bus.out_last), 64'(b.last));
                end
            end
        end
    end

    task automatic drive(int ph, int c);
        logic [P-1:0] v;
        for (int i = 0; i < P; i++) begin
            bus.in_data[i] = {$urandom, $urandom};
            bus.in_last[i] = ($urandom_range(2) == 0);
        end
        v = '0;
        rst = 1'b0;
        case (ph)
            0: begin
                v = '1;
                bus.out_ready = 1'b1;
            end
            1: begin
                v = P'($urandom);
                bus.out_ready = ($urandom_range(9) < 7);
            end
            2: begin
                for (int i = 0; i < P; i++) v[i] = ($urandom_range(9) == 0);
                bus.out_ready = $urandom_range(1) == 1;
            end
            3: begin
                v = (c % 4 < 2) ? P'(16'h8000) : P'(16'h0001);
                bus.out_ready = 1'b1;
            end
            4: begin
                v = P'($urandom) | P'($urandom);
                bus.out_ready = ($urandom_range(9) < 3);
            end
            5: begin
                v[5] = 1'b1;
                bus.in_data[5] = 64'hDEAD_BEEF;
                bus.out_ready = (c >= 5);
            end
            default: begin
                v = P'($urandom);
                bus.out_ready = $urandom_range(1) == 1;
                rst = ($urandom_range(14) == 0);
            end
        endcase
        bus.in_valid = v;
    endtask

    initial begin
        bus.in_valid  = P'(16'h0088);
        bus.in_last   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < P; i++) bus.in_data[i] = W'(i) * 64'h0101;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int ph = 0; ph <= 6; ph++) begin
            for (int c = 0; c < 60; c++) begin
                drive(ph, c);
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
